// File: rtl/gpio_capture_pkg.sv
// -----------------------------------------------------------------------------
// gpio_capture_pkg
// Shared definitions for the GPIO capture block:
//   - reg_off_e               : register offsets decoded from addr[7:0]
//   - DEBOUNCE_CYCLES_DEFAULT : default debounce period in clock cycles
// -----------------------------------------------------------------------------
package gpio_capture_pkg;

  typedef enum logic [7:0] {
    REG_IN      = 8'h00,  // RO : debounced pin state
    REG_RISE_EN = 8'h04,  // RW : rising-edge interrupt enables
    REG_FALL_EN = 8'h08,  // RW : falling-edge interrupt enables
    REG_PEND    = 8'h0C,  // RO, write-1-to-clear : pending edge flags
    REG_RAW     = 8'h10   // RO : synchronized, undebounced pin state
  } reg_off_e;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 16;

endpackage : gpio_capture_pkg

// File: rtl/gpio_capture_debounce.sv
// -----------------------------------------------------------------------------
// gpio_debounce_t
// One input pin: two-flop synchronizer followed by the stable-value flop.
//
// Build option GPIO_DEBOUNCE_EN:
//   defined   : the stable value only takes a new sync value after that value
//               has differed from it for DEBOUNCE_CYCLES consecutive cycles.
//   undefined : the stable value is the sync value registered once
//               (pin-to-stable latency of 3 edges), no counter exists.
//
// Ports:
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low clear
//   pin_i    : asynchronous external pin
//   sync_o   : second synchronizer flop output
//   stable_o : accepted (debounced) pin value
// -----------------------------------------------------------------------------
module gpio_debounce_t #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin_i,
  output logic sync_o,
  output logic stable_o
);

  logic meta_q,   meta_d;
  logic sync_q,   sync_d;
  logic stable_q, stable_d;

`ifdef GPIO_DEBOUNCE_EN
  localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  // Count value at which the next differing cycle completes the period.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    meta_d   = pin_i;
    sync_d   = meta_q;
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        // Period complete: accept the new value, counter restarts from 0.
        stable_d = sync_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  always_comb begin
    meta_d   = pin_i;
    sync_d   = meta_q;
    stable_d = sync_q;
  end

  // The debounce period has no meaning without the counter; fold it into a
  // deliberately unconsumed signal.
  logic unused_debounce_cycles;
  assign unused_debounce_cycles = ^DEBOUNCE_CYCLES;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge
      // value of its neighbour, which is what makes the chain a shift.
      meta_q   <= meta_d;
      sync_q   <= sync_d;
      stable_q <= stable_d;
    end
  end

  assign sync_o   = sync_q;
  assign stable_o = stable_q;

endmodule : gpio_debounce_t

// File: rtl/gpio_capture_t.sv
// -----------------------------------------------------------------------------
// gpio_capture_t
// WIDTH-pin input capture block with debouncing, per-pin rising/falling edge
// interrupt enables, write-1-to-clear pending flags and a level interrupt.
//
// Build option GPIO_DEBOUNCE_EN: enables the per-pin debounce counters in
// gpio_debounce_t; without it each pin is only synchronized and registered.
//
// Register map (addr[7:0]): 0x00 IN, 0x04 RISE_EN, 0x08 FALL_EN,
//                           0x0C PEND (W1C), 0x10 RAW. Others read 0.
//
// Ports:
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low clear (deassertion synchronized outside)
//   wen     : write strobe for the current cycle
//   addr    : register address, only addr[7:0] decoded
//   wdata   : write data, bits above WIDTH-1 ignored
//   gpio_in : asynchronous external pins
//   rdata   : registered read data for the addr of the previous cycle
//   irq     : OR of all pending flags, driven straight from the PEND flops
// -----------------------------------------------------------------------------
module gpio_capture_t
  import gpio_capture_pkg::*;
#(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wen,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [31:0]      rdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] stable;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    gpio_debounce_t #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk      (clk),
      .reset_n  (reset_n),
      .pin_i    (gpio_in[i]),
      .sync_o   (sync[i]),
      .stable_o (stable[i])
    );
  end

  logic [WIDTH-1:0] prev_q,    prev_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] pend_q,    pend_d;
  logic [31:0]      rdata_q,   rdata_d;

  logic [7:0]       off;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] pend_clr;

  assign off = addr[7:0];

  always_comb begin
    prev_d    = stable;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    pend_clr  = '0;

    // prev_q is the stable value one edge ago, so an edge found here sets
    // PEND on the edge after the stable value changed.
    edge_set = (stable & ~prev_q & rise_en_q) | (~stable & prev_q & fall_en_q);

    if (wen) begin
      case (off)
        REG_RISE_EN: rise_en_d = wdata[WIDTH-1:0];
        REG_FALL_EN: fall_en_d = wdata[WIDTH-1:0];
        REG_PEND:    pend_clr  = wdata[WIDTH-1:0];
        default:     ;
      endcase
    end

    // Set is applied after clear so a same-cycle set wins.
    pend_d = (pend_q & ~pend_clr) | edge_set;

    rdata_d = '0;
    case (off)
      REG_IN:      rdata_d[WIDTH-1:0] = stable;
      REG_RISE_EN: rdata_d[WIDTH-1:0] = rise_en_q;
      REG_FALL_EN: rdata_d[WIDTH-1:0] = fall_en_q;
      REG_PEND:    rdata_d[WIDTH-1:0] = pend_q;
      REG_RAW:     rdata_d[WIDTH-1:0] = sync;
      default:     ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q    <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      pend_q    <= '0;
      rdata_q   <= '0;
    end else begin
      prev_q    <= prev_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      pend_q    <= pend_d;
      rdata_q   <= rdata_d;
    end
  end

  assign rdata = rdata_q;
  assign irq   = |pend_q;

  // Upper address bits and upper write-data bits are ignored by design.
  logic unused_bus_bits;
  assign unused_bus_bits = ^{addr[31:8], wdata};

endmodule : gpio_capture_t
